spi_arb: RTL and testbench

- Round-robin arbiter sharing one spi core register port (addr/we/re/wd/rd) between N requesters, e.g. CPU bridge, DMA and boot-flash loader.
- Sits between the requesters and the spi core.
- Grant is held per requester across a multi-access SPI sequence (config, tx, poll, rx), with optional lock and a fairness hold limit.
- Routes the spi core irq to the current or most recent owner.

---
 rtl/spi_arb_pkg.sv | 36 +++
 rtl/spi_arb_rr.sv | 27 ++
 rtl/spi_arb.sv | 166 ++++++++++++++++
 tb/tb_spi_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and the round-robin pick helper for the spi core register-port arbiter.
package spi_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_N     = 8;
    localparam int unsigned PTR_W_MAX = $clog2(MAX_N);

    // One-hot pick of the first set req bit at or after ptr, wrapping at n (not at a power of two).
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input int unsigned      ptr,
                                                 input int unsigned      n);
        logic [MAX_N-1:0]     oh;
        logic                 found;
        int unsigned          k;
        logic [PTR_W_MAX-1:0] ks;
        oh    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                k = ptr + i;
                if (k >= n) k = k - n;
                ks = k[PTR_W_MAX-1:0];
                if (!found && req[ks]) begin
                    oh[ks] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Combinational round-robin picker: one-hot grant candidate and its index.
module spi_arb_rr
    import spi_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    logic [MAX_N-1:0] oh;

    always_comb begin
        oh      = rr_pick(MAX_N'(req_i), 32'(ptr_i), N);
        pick_o  = oh[N-1:0];
        valid_o = |oh;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[i]) idx_o = PW'(i);
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin owner arbiter for the spi core register port, with lock, fairness hold
// limit and irq routing to the current or most recent owner.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned AW      = 5,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*AW-1:0] r_addr,
    input  logic [N-1:0]    r_we,
    input  logic [N-1:0]    r_re,
    input  logic [N*32-1:0] r_wd,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic [31:0]     r_rd,
    output logic [AW-1:0]   addr,
    output logic            we,
    output logic            re,
    output logic [31:0]     wd,
    input  logic [31:0]     rd,
    input  logic            irq_in,
    output logic [N-1:0]    irq
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned HW = $clog2(MAXHOLD + 1);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] last_q, last_d;
    logic          last_vld_q, last_vld_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  irq_q, irq_d;
    logic [31:0]   rd_q, rd_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  pick_oh;
    logic [PW-1:0] pick_idx;
    logic          pick_vld;

    logic          o_gnt, o_we, o_re, o_req, o_lock, others_req, release_c;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wd;

    spi_arb_rr #(
        .N  (N),
        .PW (PW)
    ) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        o_gnt      = 1'b0;
        o_we       = 1'b0;
        o_re       = 1'b0;
        o_req      = 1'b0;
        o_lock     = 1'b0;
        others_req = 1'b0;
        sel_addr   = '0;
        sel_wd     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == PW'(i)) begin
                o_gnt    = gnt_q[i];
                o_we     = r_we[i];
                o_re     = r_re[i];
                o_req    = req[i];
                o_lock   = lock[i];
                sel_addr = r_addr[i*AW +: AW];
                sel_wd   = r_wd[i*32 +: 32];
            end else begin
                others_req = others_req | req[i];
            end
        end
        // gnt_q is only non-zero in OWNED, so gating on it zeroes the core port in IDLE.
        we   = o_gnt & o_we;
        re   = o_gnt & o_re & ~o_we;
        addr = o_gnt ? sel_addr : '0;
        wd   = o_gnt ? sel_wd : '0;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        rd_d       = rd_q;
        hold_d     = hold_q;
        release_c  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            irq_d[i] = irq_in & last_vld_q & (last_q == PW'(i));
        end
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d      = pick_oh;
                    owner_d    = pick_idx;
                    last_d     = pick_idx;
                    last_vld_d = 1'b1;
                    hold_d     = '0;
                    state_d    = OWNED;
                end
            end
            OWNED: begin
                if (we | re) begin
                    ack_d = gnt_q;
                    if (hold_q != HW'(MAXHOLD)) hold_d = hold_q + 1'b1;
                end
                if (re) rd_d = rd;
                release_c = ~o_req |
                            (~o_lock & (hold_q == HW'(MAXHOLD)) & others_req & ~(o_we | o_re));
                if (release_c) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            gnt_q      <= '0;
            ack_q      <= '0;
            irq_q      <= '0;
            rd_q       <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            rd_q       <= rd_d;
            hold_q     <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign irq  = irq_q;
    assign r_rd = rd_q;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb (N=2, AW=5, MAXHOLD=4) with hand-computed expectations.
module tb_spi_arb;

    logic        clk;
    logic        rstn;
    logic [1:0]  req, lock, r_we, r_re, gnt, ack, irq;
    logic [9:0]  r_addr;
    logic [63:0] r_wd;
    logic [31:0] r_rd, wd, rd;
    logic [4:0]  addr;
    logic        we, re, irq_in;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    spi_arb #(
        .N       (2),
        .AW      (5),
        .MAXHOLD (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .lock   (lock),
        .r_addr (r_addr),
        .r_we   (r_we),
        .r_re   (r_re),
        .r_wd   (r_wd),
        .gnt    (gnt),
        .ack    (ack),
        .r_rd   (r_rd),
        .addr   (addr),
        .we     (we),
        .re     (re),
        .wd     (wd),
        .rd     (rd),
        .irq_in (irq_in),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_strobes();
        r_we = '0;
        r_re = '0;
    endtask

    initial begin
        rstn = 1'b0; req = '0; lock = '0; r_we = '0; r_re = '0;
        r_addr = '0; r_wd = '0; rd = '0; irq_in = 1'b0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rrd", r_rd, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_port", {25'(addr), we, re, 5'(wd)}, 0);
        rstn = 1'b1;
        tick();

        // single requester write
        req = 2'b01; #1;
        chk("w_nogrant_same", 32'(gnt), 0);
        tick();
        chk("w_gnt", 32'(gnt), 32'h1);
        r_we[0] = 1'b1; r_addr[4:0] = 5'h04; r_wd[31:0] = 32'hA5; #1;
        chk("w_we", 32'(we), 1);
        chk("w_re", 32'(re), 0);
        chk("w_addr", 32'(addr), 32'h04);
        chk("w_wd", wd, 32'hA5);
        chk("w_ack_early", 32'(ack), 0);
        tick();
        chk("w_ack", 32'(ack), 32'h1);
        clr_strobes(); req = '0;
        tick();
        chk("w_release", 32'(gnt), 0);
        chk("w_ack_pulse", 32'(ack), 0);
        tick();

        // read by requester 1 while requester 0 strobes re as a non-owner
        req = 2'b10;
        tick();
        chk("r_gnt", 32'(gnt), 32'h2);
        r_re = 2'b11; r_addr[9:5] = 5'h08; rd = 32'h1234_5678; #1;
        chk("r_re", 32'(re), 1);
        chk("r_addr", 32'(addr), 32'h08);
        tick();
        chk("r_ack", 32'(ack), 32'h2);
        chk("r_rrd", r_rd, 32'h1234_5678);
        clr_strobes(); rd = '0; req = '0;
        tick();
        chk("r_release", 32'(gnt), 0);
        tick();

        // fairness: pointer back at 0, both requesting, owner 0 makes MAXHOLD accesses
        req = 2'b11;
        tick();
        chk("f_gnt0", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            r_we[0] = 1'b1;
            tick();
            chk("f_ack", 32'(ack), 32'h1);
        end
        clr_strobes(); #1;
        chk("f_gnt_held", 32'(gnt), 32'h1);
        tick();
        chk("f_idle_gap", 32'(gnt), 0);
        chk("f_ack_done", 32'(ack), 0);
        tick();
        chk("f_gnt1", 32'(gnt), 32'h2);
        req = 2'b01;
        tick();
        chk("f_rel1", 32'(gnt), 0);
        tick();
        chk("f_ptr0_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("f_rel0", 32'(gnt), 0);
        tick();

        // lock: owner 0 is not preempted past MAXHOLD
        req = 2'b01; lock = 2'b01;
        tick();
        chk("l_gnt0", 32'(gnt), 32'h1);
        req = 2'b11;
        for (int i = 0; i < 20; i++) begin
            r_we[0] = 1'b1;
            tick();
            chk("l_ack", 32'(ack), 32'h1);
            chk("l_gnt", 32'(gnt), 32'h1);
        end
        clr_strobes();
        tick();
        chk("l_gnt_nostrobe", 32'(gnt), 32'h1);
        req = 2'b10;
        tick();
        chk("l_rel", 32'(gnt), 0);
        tick();
        chk("l_gnt1", 32'(gnt), 32'h2);
        lock = '0;

        // collisions with owner 1
        r_we[0] = 1'b1; r_re[0] = 1'b1; r_addr[4:0] = 5'h1F; #1;
        chk("c_nonowner_we", 32'(we), 0);
        chk("c_nonowner_re", 32'(re), 0);
        tick();
        chk("c_nonowner_ack", 32'(ack), 0);
        clr_strobes();
        r_we[1] = 1'b1; r_re[1] = 1'b1; r_wd[63:32] = 32'hDEAD_BEEF; rd = 32'hCAFE_F00D; #1;
        chk("c_both_we", 32'(we), 1);
        chk("c_both_re", 32'(re), 0);
        chk("c_both_wd", wd, 32'hDEAD_BEEF);
        tick();
        chk("c_both_ack", 32'(ack), 32'h2);
        chk("c_rrd_kept", r_rd, 32'h1234_5678);
        clr_strobes(); rd = '0;
        tick();
        chk("c_one_ack", 32'(ack), 0);
        irq_in = 1'b1; #1;
        chk("c_irq_reg", 32'(irq), 0);
        tick();
        chk("c_irq", 32'(irq), 32'h2);
        irq_in = 1'b0;
        tick();
        chk("c_irq_drop", 32'(irq), 0);

        // asynchronous reset in the middle of an owner strobe
        irq_in = 1'b1; r_we[1] = 1'b1;
        tick();
        chk("x_pre_ack", 32'(ack), 32'h2);
        chk("x_pre_irq", 32'(irq), 32'h2);
        rstn = 1'b0; #1;
        chk("x_gnt", 32'(gnt), 0);
        chk("x_ack", 32'(ack), 0);
        chk("x_irq", 32'(irq), 0);
        chk("x_we", 32'(we), 0);
        clr_strobes(); irq_in = 1'b0; req = '0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        req = 2'b10; #1;
        chk("x_regrant_wait", 32'(gnt), 0);
        tick();
        chk("x_regrant", 32'(gnt), 32'h2);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
